// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler
// Keeps the newest sample for each DAC channel and, once per INTERVAL clocks,
// walks the channels from lowest to highest. For each channel it hands one
// 24-bit MAX5134 write frame {CMD_PREFIX, one-hot select, sample} to the SPI
// serialiser over a send/busy handshake. Rounds that cannot start because
// the previous one is still running are dropped and flagged. Frames the
// serialiser never acknowledges are abandoned and flagged.
module dac_channel_scheduler #(
    parameter int         NUM_CH      = 4,
    parameter int         DATA_W      = 16,
    parameter int         INTERVAL    = 3624,
    parameter logic [3:0] CMD_PREFIX  = 4'b0011,
    parameter bit         DIRTY_ONLY  = 1'b0,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic                     fpga_clock,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    input  logic [NUM_CH-1:0]        sample_valid,
    input  logic                     dac_busy,
    output logic [23:0]              dac_data,
    output logic                     dac_send,
    output logic                     round_active,
    output logic                     overrun,
    output logic                     ack_error
);

    localparam int CNT_W = $clog2(INTERVAL);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t state_q;
    state_t state_n;

    logic [CNT_W-1:0]  int_cnt;
    logic              tick;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] shadow   [NUM_CH];
    logic [DATA_W-1:0] snapshot [NUM_CH];
    logic [NUM_CH-1:0] dirty;
    logic [NUM_CH-1:0] pending;
    logic [1:0]        ch;
    logic [1:0]        first_ch;
    logic [3:0]        ch_sel;

    // FSM strobes consumed by the datapath registers
    logic start_round;
    logic do_load;
    logic do_send;
    logic clr_pend;
    logic set_ack;

    assign tick   = enable && (int_cnt == CNT_LAST);
    assign ch_sel = 4'b0001 << ch;

    // Interval counter: free-runs 0..INTERVAL-1 while enabled, parked at 0 otherwise
    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            int_cnt <= '0;
        end else if (!enable || tick) begin
            int_cnt <= '0;
        end else begin
            int_cnt <= int_cnt + 1'b1;
        end
    end

    // Lowest pending channel; the scan runs high-to-low so the lowest index wins
    always_comb begin
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                first_ch = 2'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next-state and per-cycle strobes
    always_comb begin
        state_n     = state_q;
        start_round = 1'b0;
        do_load     = 1'b0;
        do_send     = 1'b0;
        clr_pend    = 1'b0;
        set_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    start_round = 1'b1;
                    state_n     = LOAD;
                end
            end
            LOAD: begin
                do_load = 1'b1;
                state_n = (pending == '0) ? IDLE : SEND;
            end
            SEND: begin
                if (!dac_busy) begin
                    do_send = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (dac_busy) begin
                    state_n = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    set_ack  = 1'b1;
                    clr_pend = 1'b1;
                    state_n  = LOAD;
                end
            end
            WAIT_DONE: begin
                if (!dac_busy) begin
                    clr_pend = 1'b1;
                    state_n  = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sample capture: shadows track the inputs; the snapshot freezes them at round start.
    // A strobe landing on the round-start cycle goes to the shadow and stays dirty for the next round.
    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i]   <= '0;
                snapshot[i] <= '0;
            end
            dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sample_valid[i]) begin
                    shadow[i] <= sample_data[i*DATA_W +: DATA_W];
                end
                if (start_round) begin
                    snapshot[i] <= shadow[i];
                end
            end
            dirty <= (start_round ? '0 : dirty) | sample_valid;
        end
    end

    // Round bookkeeping: pending mask, current channel and ack timeout counter
    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ch      <= '0;
            to_cnt  <= '0;
        end else begin
            if (start_round) begin
                pending <= DIRTY_ONLY ? dirty : {NUM_CH{1'b1}};
            end else if (clr_pend) begin
                pending[ch] <= 1'b0;
            end
            if (do_load) begin
                ch <= first_ch;
            end
            if (do_send) begin
                to_cnt <= '0;
            end else if (state_q == WAIT_ACK && !dac_busy) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Serialiser interface and status flags. round_active drops one clock after
    // the FSM returns to IDLE, so an empty round still shows a two-clock pulse.
    always_ff @(posedge fpga_clock or posedge rst) begin
        if (rst) begin
            dac_data     <= '0;
            dac_send     <= 1'b0;
            round_active <= 1'b0;
            overrun      <= 1'b0;
            ack_error    <= 1'b0;
        end else begin
            dac_send <= do_send;
            if (do_send) begin
                dac_data <= {CMD_PREFIX, ch_sel, snapshot[ch]};
            end
            if (start_round) begin
                round_active <= 1'b1;
            end else if (state_q == IDLE) begin
                round_active <= 1'b0;
            end
            if (tick && state_q != IDLE) begin
                overrun <= 1'b1;
            end
            if (set_ack) begin
                ack_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Testbench for dac_channel_scheduler: one instance sends every channel each
// round, a second only sends channels updated since their last send. Each
// instance has its own serialiser model with a configurable busy length and
// an option to never acknowledge. Expected frames are queued when stimulus
// is applied and checked as dac_send pulses appear.
module tb_dac_channel_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // instance A: DIRTY_ONLY=0
    logic        a_en    = 1'b0;
    logic [63:0] a_sdata = '0;
    logic [3:0]  a_svld  = '0;
    logic        a_busy;
    logic [23:0] a_data;
    logic        a_send, a_ra, a_ovr, a_ack;
    int          a_blen  = 50;
    logic        a_noack = 1'b0;
    int          a_rem;

    // instance B: DIRTY_ONLY=1
    logic        b_en    = 1'b0;
    logic [63:0] b_sdata = '0;
    logic [3:0]  b_svld  = '0;
    logic        b_busy;
    logic [23:0] b_data;
    logic        b_send, b_ra, b_ovr, b_ack;
    int          b_blen  = 50;
    logic        b_noack = 1'b0;
    int          b_rem;

    logic [23:0] qa[$];
    logic [23:0] qb[$];
    int          a_cyc[$];
    int          b_cyc[$];

    dac_channel_scheduler #(
        .NUM_CH(4), .DATA_W(16), .INTERVAL(100), .CMD_PREFIX(4'b0011),
        .DIRTY_ONLY(1'b0), .ACK_TIMEOUT(15)
    ) u_all (
        .fpga_clock(clk), .rst(rst), .enable(a_en), .sample_data(a_sdata),
        .sample_valid(a_svld), .dac_busy(a_busy), .dac_data(a_data),
        .dac_send(a_send), .round_active(a_ra), .overrun(a_ovr), .ack_error(a_ack)
    );

    dac_channel_scheduler #(
        .NUM_CH(4), .DATA_W(16), .INTERVAL(100), .CMD_PREFIX(4'b0011),
        .DIRTY_ONLY(1'b1), .ACK_TIMEOUT(15)
    ) u_dirty (
        .fpga_clock(clk), .rst(rst), .enable(b_en), .sample_data(b_sdata),
        .sample_valid(b_svld), .dac_busy(b_busy), .dac_data(b_data),
        .dac_send(b_send), .round_active(b_ra), .overrun(b_ovr), .ack_error(b_ack)
    );

    // serialiser model A: busy rises one clock after dac_send, lasts a_blen clocks
    always @(posedge clk) begin
        if (rst) begin
            a_busy <= 1'b0;
            a_rem  <= 0;
        end else if (a_send && !a_noack) begin
            a_busy <= 1'b1;
            a_rem  <= a_blen;
        end else if (a_rem > 1) begin
            a_rem <= a_rem - 1;
        end else if (a_rem == 1) begin
            a_rem  <= 0;
            a_busy <= 1'b0;
        end
    end

    // serialiser model B
    always @(posedge clk) begin
        if (rst) begin
            b_busy <= 1'b0;
            b_rem  <= 0;
        end else if (b_send && !b_noack) begin
            b_busy <= 1'b1;
            b_rem  <= b_blen;
        end else if (b_rem > 1) begin
            b_rem <= b_rem - 1;
        end else if (b_rem == 1) begin
            b_rem  <= 0;
            b_busy <= 1'b0;
        end
    end

    // scoreboard: every dac_send pops one expected frame
    always @(negedge clk) begin
        logic [23:0] exp_f;
        if (!rst) begin
            if (a_send) begin
                a_cyc.push_back(cyc);
                n_cmp++;
                if (a_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL a_send_while_busy: dac_busy=%0b at cycle %0d, required 0", a_busy, cyc);
                end
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++;
                    $display("FAIL a_frame: got %h at cycle %0d, required no frame", a_data, cyc);
                end else begin
                    exp_f = qa.pop_front();
                    if (a_data !== exp_f) begin
                        n_bad++;
                        $display("FAIL a_frame: got %h at cycle %0d, required %h", a_data, cyc, exp_f);
                    end
                end
            end
            if (b_send) begin
                b_cyc.push_back(cyc);
                n_cmp++;
                if (b_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b_send_while_busy: dac_busy=%0b at cycle %0d, required 0", b_busy, cyc);
                end
                n_cmp++;
                if (qb.size() == 0) begin
                    n_bad++;
                    $display("FAIL b_frame: got %h at cycle %0d, required no frame", b_data, cyc);
                end else begin
                    exp_f = qb.pop_front();
                    if (b_data !== exp_f) begin
                        n_bad++;
                        $display("FAIL b_frame: got %h at cycle %0d, required %h", b_data, cyc, exp_f);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sends_a(input int n, input int budget);
        int k = 0;
        while (a_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (a_cyc.size() < n) begin
            n_bad++;
            $display("FAIL a_send_count: got %0d sends, required %0d", a_cyc.size(), n);
        end
    endtask

    task automatic wait_sends_b(input int n, input int budget);
        int k = 0;
        while (b_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (b_cyc.size() < n) begin
            n_bad++;
            $display("FAIL b_send_count: got %0d sends, required %0d", b_cyc.size(), n);
        end
    endtask

    task automatic strobe_b(input int ch, input logic [15:0] v);
        step();
        b_sdata[ch*16 +: 16] = v;
        b_svld = 4'b0001 << ch;
        step();
        b_svld = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_data, a_send, a_ra, a_ovr, a_ack} !== 28'h0) begin
            n_bad++;
            $display("FAIL reset_a: got %h, required 0", {a_data, a_send, a_ra, a_ovr, a_ack});
        end
        n_cmp++;
        if ({b_data, b_send, b_ra, b_ovr, b_ack} !== 28'h0) begin
            n_bad++;
            $display("FAIL reset_b: got %h, required 0", {b_data, b_send, b_ra, b_ovr, b_ack});
        end
        step();
        rst = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_dirty_single();
        int e;
        int cnt = 0;
        strobe_b(2, 16'hBEEF);
        qb.push_back(24'h34BEEF);
        step();
        b_en = 1'b1;
        e = cyc;
        wait_sends_b(1, 300);
        n_cmp++;
        if (b_cyc[0] !== e + 102) begin
            n_bad++;
            $display("FAIL b_first_latency: got cycle %0d, required %0d", b_cyc[0], e + 102);
        end
        wait_cycle(e + 170);
        repeat (80) begin
            @(negedge clk);
            if (b_ra) cnt++;
        end
        n_cmp++;
        if (cnt !== 2) begin
            n_bad++;
            $display("FAIL b_empty_round_width: got %0d clocks, required 2", cnt);
        end
        n_cmp++;
        if (b_cyc.size() !== 1 || qb.size() !== 0) begin
            n_bad++;
            $display("FAIL b_empty_round_sends: got %0d sends, required 1", b_cyc.size());
        end
        step();
        b_en = 1'b0;
    endtask

    task automatic test_tick_strobe();
        int e;
        strobe_b(0, 16'h5555);
        qb.push_back(24'h315555);
        qb.push_back(24'h31AAAA);
        step();
        b_en = 1'b1;
        e = cyc;
        wait_cycle(e + 99);
        b_sdata[15:0] = 16'hAAAA;
        b_svld = 4'b0001;
        step();
        b_svld = '0;
        wait_sends_b(3, 300);
        n_cmp++;
        if (b_cyc[1] !== e + 102) begin
            n_bad++;
            $display("FAIL b_tick_strobe_old: got cycle %0d, required %0d", b_cyc[1], e + 102);
        end
        n_cmp++;
        if (b_cyc[2] !== e + 202) begin
            n_bad++;
            $display("FAIL b_tick_strobe_new: got cycle %0d, required %0d", b_cyc[2], e + 202);
        end
        step();
        b_en = 1'b0;
        repeat (100) step();
        n_cmp++;
        if (b_cyc.size() !== 3 || b_ra !== 1'b0) begin
            n_bad++;
            $display("FAIL b_tick_strobe_end: got %0d sends ra=%0b, required 3 sends ra=0", b_cyc.size(), b_ra);
        end
    endtask

    task automatic test_rounds();
        int e;
        a_blen = 20;
        step();
        a_sdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        a_svld  = 4'hF;
        step();
        a_svld = '0;
        repeat (2) begin
            qa.push_back(24'h311111);
            qa.push_back(24'h322222);
            qa.push_back(24'h343333);
            qa.push_back(24'h384444);
        end
        step();
        a_en = 1'b1;
        e = cyc;
        wait_cycle(e + 250);
        a_en = 1'b0;
        wait_sends_a(8, 200);
        n_cmp++;
        if (a_cyc[0] !== e + 102) begin
            n_bad++;
            $display("FAIL a_first_latency: got cycle %0d, required %0d", a_cyc[0], e + 102);
        end
        n_cmp++;
        if (a_cyc[1] !== e + 126) begin
            n_bad++;
            $display("FAIL a_next_frame: got cycle %0d, required %0d", a_cyc[1], e + 126);
        end
        n_cmp++;
        if (a_cyc[4] !== e + 202) begin
            n_bad++;
            $display("FAIL a_round_period: got cycle %0d, required %0d", a_cyc[4], e + 202);
        end
        n_cmp++;
        if (a_cyc[7] !== e + 274) begin
            n_bad++;
            $display("FAIL a_round_after_disable: got cycle %0d, required %0d", a_cyc[7], e + 274);
        end
        repeat (300) step();
        n_cmp++;
        if (a_cyc.size() !== 8 || a_ovr !== 1'b0 || a_ra !== 1'b0) begin
            n_bad++;
            $display("FAIL a_disabled_quiet: got %0d sends ovr=%0b ra=%0b, required 8 sends ovr=0 ra=0",
                     a_cyc.size(), a_ovr, a_ra);
        end
    endtask

    task automatic test_reenable();
        int e;
        qa.push_back(24'h311111);
        qa.push_back(24'h322222);
        qa.push_back(24'h343333);
        qa.push_back(24'h384444);
        step();
        a_en = 1'b1;
        e = cyc;
        wait_cycle(e + 150);
        a_en = 1'b0;
        wait_sends_a(12, 200);
        n_cmp++;
        if (a_cyc[8] !== e + 102) begin
            n_bad++;
            $display("FAIL a_reenable_latency: got cycle %0d, required %0d", a_cyc[8], e + 102);
        end
        n_cmp++;
        if (a_cyc[11] !== e + 174) begin
            n_bad++;
            $display("FAIL a_reenable_last: got cycle %0d, required %0d", a_cyc[11], e + 174);
        end
        repeat (250) step();
        n_cmp++;
        if (a_cyc.size() !== 12 || a_ra !== 1'b0) begin
            n_bad++;
            $display("FAIL a_reenable_end: got %0d sends ra=%0b, required 12 sends ra=0", a_cyc.size(), a_ra);
        end
    endtask

    task automatic test_overrun();
        int e;
        a_blen = 400;
        qa.push_back(24'h311111);
        qa.push_back(24'h322222);
        qa.push_back(24'h343333);
        qa.push_back(24'h384444);
        step();
        a_en = 1'b1;
        e = cyc;
        wait_cycle(e + 150);
        n_cmp++;
        if (a_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL a_overrun_early: got %0b, required 0", a_ovr);
        end
        wait_cycle(e + 201);
        n_cmp++;
        if (a_ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL a_overrun_set: got %0b, required 1", a_ovr);
        end
        wait_sends_a(16, 1500);
        step();
        a_en = 1'b0;
        repeat (450) step();
        n_cmp++;
        if (a_cyc[12] !== e + 102 || a_cyc[13] !== e + 506) begin
            n_bad++;
            $display("FAIL a_overrun_timing: got cycles %0d/%0d, required %0d/%0d",
                     a_cyc[12], a_cyc[13], e + 102, e + 506);
        end
        n_cmp++;
        if (a_cyc.size() !== 16 || qa.size() !== 0 || a_ra !== 1'b0 || a_ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL a_overrun_end: got %0d sends ra=%0b ovr=%0b, required 16 sends ra=0 ovr=1",
                     a_cyc.size(), a_ra, a_ovr);
        end
    endtask

    task automatic test_ack_reset();
        int e;
        int s;
        a_blen  = 50;
        a_noack = 1'b1;
        qa.push_back(24'h311111);
        qa.push_back(24'h322222);
        step();
        a_en = 1'b1;
        e = cyc;
        wait_sends_a(17, 300);
        s = a_cyc[16];
        n_cmp++;
        if (s !== e + 102) begin
            n_bad++;
            $display("FAIL a_ack_first: got cycle %0d, required %0d", s, e + 102);
        end
        wait_cycle(s + 2);
        a_noack = 1'b0;
        wait_cycle(s + 14);
        @(negedge clk);
        n_cmp++;
        if (a_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL a_ack_early: got %0b, required 0", a_ack);
        end
        wait_cycle(s + 15);
        @(negedge clk);
        n_cmp++;
        if (a_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL a_ack_error: got %0b, required 1", a_ack);
        end
        wait_sends_a(18, 50);
        n_cmp++;
        if (a_cyc[17] !== s + 17) begin
            n_bad++;
            $display("FAIL a_after_timeout: got cycle %0d, required %0d", a_cyc[17], s + 17);
        end
        a_en = 1'b0;
        wait_cycle(s + 40);
        n_cmp++;
        if (a_ra !== 1'b1) begin
            n_bad++;
            $display("FAIL a_mid_wait_done: got ra=%0b, required 1", a_ra);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_data, a_send, a_ra, a_ovr, a_ack} !== 28'h0) begin
            n_bad++;
            $display("FAIL a_async_reset: got %h, required 0", {a_data, a_send, a_ra, a_ovr, a_ack});
        end
        qa.delete();
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (a_ra !== 1'b0 || a_cyc.size() !== 18) begin
            n_bad++;
            $display("FAIL a_post_reset: got ra=%0b sends=%0d, required ra=0 sends=18", a_ra, a_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_dirty_single();
        test_tick_strobe();
        test_rounds();
        test_reenable();
        test_overrun();
        test_ack_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
